// File: rtl/game_pkg.sv
// Shared types and constants for the game datapath blocks.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLLING,
    WAIT_DONE
  } roller_state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One right shift of the Galois LFSR for x^16+x^14+x^13+x^11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads the seed if it ever locks up at zero.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= seed;
    end else if (out == 16'h0000) begin
      out <= seed;
    end else begin
      out <= lfsr_step(out);
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Button-triggered dice roll: timed tumbling animation, one-cycle result pulse,
// then lockout until game_logic signals the turn is finished.
module dice_roller
  import game_pkg::*;
#(
  parameter int          ROLL_CYCLES  = 50_000_000,
  parameter int          FRAME_CYCLES = 5_000_000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       roll_btn,
  input  logic       turn_done,
  output logic [1:0] dice_value,
  output logic       dice_valid,
  output logic       rolling,
  output logic       busy,
  output logic [1:0] anim_face
);

  localparam int RW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [RW-1:0] ROLL_LAST  = RW'(ROLL_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

  roller_state_t state, state_next;
  logic          btn_prev;
  logic          rise;
  logic [15:0]   lfsr_q;
  logic [1:0]    sample;
  logic [RW-1:0] roll_cnt, roll_cnt_next;
  logic [FW-1:0] frame_cnt, frame_cnt_next;
  logic [1:0]    value_next, anim_next;
  logic          valid_next, rolling_next, busy_next;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .out   (lfsr_q)
  );

  assign sample = lfsr_q[1:0];
  assign rise   = roll_btn & ~btn_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping enable aborts from any busy state, taking priority over completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable && rise) state_next = ROLLING;
      ROLLING:   if (!enable) state_next = IDLE;
                 else if (roll_cnt == '0) state_next = WAIT_DONE;
      WAIT_DONE: if (!enable || turn_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    roll_cnt_next  = roll_cnt;
    frame_cnt_next = frame_cnt;
    value_next     = dice_value;
    anim_next      = anim_face;
    valid_next     = 1'b0;
    rolling_next   = (state_next == ROLLING);
    busy_next      = (state_next != IDLE);
    case (state)
      IDLE: begin
        if (enable && rise) begin
          roll_cnt_next  = ROLL_LAST;
          frame_cnt_next = FRAME_LAST;
          anim_next      = sample;
        end
      end
      ROLLING: begin
        if (enable) begin
          if (roll_cnt == '0) begin
            value_next = sample;
            anim_next  = sample;
            valid_next = 1'b1;
          end else begin
            roll_cnt_next = roll_cnt - RW'(1);
            if (frame_cnt == '0) begin
              frame_cnt_next = FRAME_LAST;
              anim_next      = sample;
            end else begin
              frame_cnt_next = frame_cnt - FW'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // btn_prev resets high so a button held through reset release is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev   <= 1'b1;
      roll_cnt   <= '0;
      frame_cnt  <= '0;
      dice_value <= 2'd0;
      dice_valid <= 1'b0;
      rolling    <= 1'b0;
      busy       <= 1'b0;
      anim_face  <= 2'd0;
    end else begin
      btn_prev   <= roll_btn;
      roll_cnt   <= roll_cnt_next;
      frame_cnt  <= frame_cnt_next;
      dice_value <= value_next;
      dice_valid <= valid_next;
      rolling    <= rolling_next;
      busy       <= busy_next;
      anim_face  <= anim_next;
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller with a short roll (20 cycles) and frame (4 cycles).
module tb_dice_roller;

  localparam int          R    = 20;
  localparam int          F    = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset, enable, roll_btn, turn_done;
  logic [1:0] dice_value, anim_face;
  logic       dice_valid, rolling, busy;

  int         checks = 0;
  int         failures = 0;
  int         zero_seen = 0;
  int         lfsr_diff = 0;
  int         seen [4];
  logic [15:0] m_lfsr;
  logic [1:0]  last_val;
  logic [1:0]  v;

  dice_roller #(
    .ROLL_CYCLES  (R),
    .FRAME_CYCLES (F),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .roll_btn   (roll_btn),
    .turn_done  (turn_done),
    .dice_value (dice_value),
    .dice_valid (dice_valid),
    .rolling    (rolling),
    .busy       (busy),
    .anim_face  (anim_face)
  );

  always #5 clk = ~clk;

  // Reference Galois LFSR, x^16+x^14+x^13+x^11, shifting right.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else if (m_lfsr == 16'h0) m_lfsr <= SEED;
    else m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (dut.u_lfsr.out == 16'h0) zero_seen++;
      if (dut.u_lfsr.out != m_lfsr) lfsr_diff++;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic btn, input logic en, input logic td);
    roll_btn  = btn;
    enable    = en;
    turn_done = td;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called just after a negedge in IDLE with roll_btn low; returns at the dice_valid cycle.
  task automatic do_roll(input bit press_mid, output logic [1:0] val);
    logic [1:0] exp_anim, exp_val;
    exp_val  = 2'd0;
    roll_btn = 1'b1;
    exp_anim = m_lfsr[1:0];
    for (int k = 1; k <= R + 1; k++) begin
      tick();
      checkOutput("rolling", rolling, (k <= R) ? 1 : 0);
      checkOutput("busy", busy, 1);
      checkOutput("dice_valid", dice_valid, (k == R + 1) ? 1 : 0);
      checkOutput("anim_face", anim_face, exp_anim);
      if (k == R + 1) checkOutput("dice_value", dice_value, exp_val);
      if (k <= R && ((k % F) == 0 || k == R)) exp_anim = m_lfsr[1:0];
      if (k == R) exp_val = m_lfsr[1:0];
      if (k == 1) roll_btn = 1'b0;
      if (press_mid && k == 5) roll_btn = 1'b1;
      if (press_mid && k == 6) roll_btn = 1'b0;
    end
    val = exp_val;
  endtask

  task automatic press_in_wait();
    roll_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("wait_valid", dice_valid, 0);
      checkOutput("wait_busy", busy, 1);
      checkOutput("wait_value", dice_value, last_val);
    end
    roll_btn = 1'b0;
  endtask

  task automatic finish_turn();
    turn_done = 1'b1;
    tick();
    turn_done = 1'b0;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_rolling", rolling, 0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("rst_value", dice_value, 0);
    checkOutput("rst_valid", dice_valid, 0);
    checkOutput("rst_rolling", rolling, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_anim", anim_face, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (8) tick();

    // Roll with a mid-roll press, a press in WAIT_DONE, then a clean second roll.
    do_roll(1'b1, v);
    last_val = v;
    press_in_wait();
    finish_turn();
    do_roll(1'b0, v);
    last_val = v;
    finish_turn();

    // turn_done and a rise in the same cycle must not start a roll.
    do_roll(1'b0, v);
    last_val = v;
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    turn_done = 1'b0;
    checkOutput("same_busy", busy, 0);
    repeat (4) begin
      tick();
      checkOutput("same_rolling", rolling, 0);
      checkOutput("same_valid", dice_valid, 0);
    end
    roll_btn = 1'b0;
    tick();
    do_roll(1'b0, v);
    last_val = v;
    finish_turn();

    // Enable drops at roll cycle 5.
    roll_btn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) roll_btn = 1'b0;
      checkOutput("abort_rolling_pre", rolling, 1);
    end
    enable = 1'b0;
    tick();
    checkOutput("abort_rolling", rolling, 0);
    checkOutput("abort_busy", busy, 0);
    repeat (R + 3) begin
      tick();
      checkOutput("abort_valid", dice_valid, 0);
      checkOutput("abort_value", dice_value, last_val);
    end
    enable = 1'b1;
    tick();

    // Asynchronous reset at roll cycle 12.
    roll_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) roll_btn = 1'b0;
    end
    reset = 1'b1;
    #1;
    checkOutput("midrst_value", dice_value, 0);
    checkOutput("midrst_rolling", rolling, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_anim", anim_face, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (R + 3) begin
      tick();
      checkOutput("postrst_valid", dice_valid, 0);
      checkOutput("postrst_rolling", rolling, 0);
      checkOutput("postrst_value", dice_value, 0);
    end
    last_val = 2'd0;

    // Button held through reset release, then a press with enable low.
    roll_btn = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) begin
      tick();
      checkOutput("held_rolling", rolling, 0);
      checkOutput("held_busy", busy, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    roll_btn = 1'b1;
    repeat (5) begin
      tick();
      checkOutput("disabled_rolling", rolling, 0);
      checkOutput("disabled_busy", busy, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();

    // Long run: every face must appear.
    for (int i = 0; i < 4; i++) seen[i] = 0;
    for (int i = 0; i < 1000; i++) begin
      do_roll(1'b0, v);
      seen[v]++;
      finish_turn();
    end
    for (int i = 0; i < 4; i++) checkOutput($sformatf("face_%0d_seen", i), (seen[i] > 0) ? 1 : 0, 1);
    checkOutput("lfsr_zero", zero_seen, 0);
    checkOutput("lfsr_model", lfsr_diff, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
- Sits directly upstream of game_logic. Replaces the switch/button dice inputs with an LFSR-based pseudo-random roll.
- Takes the debounced roll button level and the game-state enable, runs a timed "rolling" animation, then emits a single-cycle dice_valid with a 2-bit dice_value.
- Locks out further rolls until game_logic reports turn_done.
- anim_face and rolling are also exported so the renderer can draw the tumbling die.

Parameters:
- ROLL_CYCLES, 50_000_000: clk cycles spent in ROLLING (0.5 s at 100 MHz); must be >= 1.
- FRAME_CYCLES, 5_000_000: clk cycles between anim_face updates while rolling; must be >= 1.
- LFSR_SEED, 16'hACE1: nonzero LFSR reset/reload value.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- enable  in  1  high only while the system is in game state
- roll_btn  in  1  debounced roll button, level
- turn_done  in  1  game_logic single-cycle pulse: move/event finished
- dice_value  out  2  rolled result; face = dice_value + 1; held until the next result
- dice_valid  out  1  single-cycle pulse, result ready
- rolling  out  1  high in ROLLING
- busy  out  1  high in ROLLING or WAIT_DONE
- anim_face  out  2  face currently shown by the animation

Behaviour:
- Reset values:
  - dice_value = 0, dice_valid = 0, rolling = 0, busy = 0, anim_face = 0.
  - State = IDLE; LFSR = LFSR_SEED.
  - btn_prev = 1, so a button held through reset release does not roll.
- btn_prev <= roll_btn every cycle. Define rise = roll_btn & ~btn_prev.
- LFSR:
  - 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11); shifts right every cycle in all states.
  - If the register ever reads 0, reload LFSR_SEED next cycle.
  - Sample s = lfsr[1:0].
- State machine, all outputs registered:
  - IDLE:
    - If enable & rise: go to ROLLING, roll_cnt <= ROLL_CYCLES-1, frame_cnt <= FRAME_CYCLES-1, anim_face <= s.
    - rise while enable = 0 is ignored. turn_done is ignored.
  - ROLLING:
    - rolling = busy = 1. Both counters decrement each cycle.
    - When frame_cnt = 0: reload it to FRAME_CYCLES-1 and set anim_face <= s.
    - When roll_cnt = 0: go to WAIT_DONE, dice_value <= s, anim_face <= s, dice_valid <= 1.
    - rise is ignored.
  - WAIT_DONE:
    - busy = 1; dice_valid is forced back to 0 after one cycle.
    - On turn_done: go to IDLE.
    - rise is ignored, including a rise in the same cycle as turn_done; a fresh edge is required after returning to IDLE.
- Latency:
  - Let N be the cycle in which rise is sampled.
  - rolling is high from N+1 through N+ROLL_CYCLES.
  - dice_valid is high exactly at cycle N+ROLL_CYCLES+1.
  - dice_value is stable from that cycle onward.
- Abort: enable low in ROLLING or WAIT_DONE forces IDLE next cycle.
  - No dice_valid is emitted.
  - dice_value keeps its previous value.
  - Counters stop.
- Asynchronous reset mid-roll returns everything to the reset values immediately; no dice_valid is emitted.
- dice_valid never asserts in two consecutive cycles, and never asserts more than once per rise.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit.

Decomposition:
- Package game_pkg holds:
  - the roller state typedef (IDLE, ROLLING, WAIT_DONE);
  - localparam LFSR_MASK = 16'hB400.
- One sub-module, lfsr16: clk, reset, seed, out[15:0], including the zero-reload guard.
- FSM and counters stay in dice_roller.

Test Plan (ROLL_CYCLES=20, FRAME_CYCLES=4):
- Reset, then press roll_btn at cycle 10 with enable=1 -> rolling is high over cycles 11–30; dice_valid is a one-cycle pulse at 31; dice_value equals the bench lfsr16 model's [1:0] at cycle 30; busy stays high until turn_done.
- During ROLLING -> anim_face changes only at 4-cycle frame boundaries (cycles 14, 18, 22, 26, 30 for a press at 10) and always matches the model sample.
- Press again during ROLLING and during WAIT_DONE -> no extra dice_valid; pulse turn_done -> IDLE; a new press starts a new roll with exactly one dice_valid.
- turn_done and a rise in the same cycle in WAIT_DONE -> IDLE, no roll; the next fresh rise rolls.
- Drop enable at roll cycle 5; separately, assert reset at roll cycle 12 -> IDLE or reset values, no dice_valid, dice_value unchanged after the enable abort and 0 after the reset.
- Hold roll_btn high across reset deassertion; also press with enable=0 -> no roll; 1000 rolls -> every dice_value 0–3 appears, and the LFSR never reads 0.
